// File: rtl/ibex_cap_pkg.sv
// Shared types and helpers for the capability-tagged fetch FIFO.
// Addresses carry the PC in [PC_W-1:0] and capability metadata above it.
package ibex_cap_pkg;

    localparam int unsigned CAP_W = 93;
    localparam int unsigned PC_W  = 32;

    typedef struct packed {
        logic [CAP_W-1:0] addr;
        logic [31:0]      rdata;
        logic             err;
    } fifo_entry_t;

    // Any encoding other than 2'b11 in the low two bits is a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] low_bits);
        return low_bits != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_fetch_aligner.sv
// Combinational head/second word selection and halfword realignment for the fetch FIFO.
// Produces the instruction, its address, and the valid/error/compressed flags.
module ibex_fetch_aligner
    import ibex_cap_pkg::*;
#(
    parameter int unsigned ADDR_W = CAP_W
) (
    input  logic [1:0]        stored_valid,
    input  logic [ADDR_W-1:0] stored_addr,
    input  logic [31:0]       stored_head,
    input  logic [15:0]       stored_second_lo,
    input  logic [1:0]        stored_err,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_rdata,
    input  logic              in_err,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_rdata,
    output logic              out_err,
    output logic              out_compressed,
    output logic              out_valid_stored
);

    logic        head_valid;
    logic [31:0] head_rdata;
    logic        head_err;
    logic [15:0] second_lo;
    logic        second_err;
    logic        unaligned;

    // An empty head slot passes the incoming word straight through.
    assign head_valid = stored_valid[0] | in_valid;
    assign head_rdata = stored_valid[0] ? stored_head : in_rdata;
    assign head_err   = stored_valid[0] ? stored_err[0] : (in_valid & in_err);
    assign out_addr   = stored_valid[0] ? stored_addr : in_addr;

    assign second_lo  = stored_valid[1] ? stored_second_lo : in_rdata[15:0];
    assign second_err = stored_valid[1] ? stored_err[1]
                                        : (stored_valid[0] & in_valid & in_err);

    assign unaligned  = out_addr[1];

    always_comb begin
        // NOTE: every output gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
        out_rdata = head_rdata;
        out_valid = head_valid;
        out_err   = head_err;
        if (unaligned) begin
            if (is_compressed(head_rdata[17:16])) begin
                out_rdata = {16'b0, head_rdata[31:16]};
            end else begin
                // A faulting head is delivered without waiting for the second half.
                out_rdata = {second_lo, head_rdata[31:16]};
                out_valid = stored_valid[1] | (stored_valid[0] & in_valid) |
                            (head_valid & head_err);
                out_err   = head_err | second_err;
            end
        end
    end

    assign out_compressed = is_compressed(out_rdata[1:0]);

    always_comb begin
        out_valid_stored = stored_valid[0];
        if (stored_addr[1] && !is_compressed(stored_head[17:16])) begin
            out_valid_stored = stored_valid[1] | (stored_valid[0] & stored_err[0]);
        end
    end

endmodule

// File: rtl/ibex_cap_fetch_fifo.sv
// Fetch FIFO between the instruction-memory interface and IF, with halfword realignment.
// The PC in [31:0] advances by 2 or 4; capability metadata above it is carried unchanged.
module ibex_cap_fetch_fifo
    import ibex_cap_pkg::*;
#(
    parameter int unsigned       DEPTH      = 3,
    parameter int unsigned       ADDR_W     = CAP_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [31:0]       in_rdata_i,
    input  logic              in_err_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_rdata_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_err_o,
    output logic              out_is_compressed_o,
    output logic              out_valid_stored_o
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [ADDR_W-1:0] addr_d  [DEPTH];
    logic [31:0]       rdata_q [DEPTH];
    logic [31:0]       rdata_d [DEPTH];

    logic              deq;
    logic              pop;
    logic              placed;
    logic [PC_W-1:0]   pc_next;

    ibex_fetch_aligner #(
        .ADDR_W (ADDR_W)
    ) u_aligner (
        .stored_valid     (valid_q[1:0]),
        .stored_addr      (addr_q[0]),
        .stored_head      (rdata_q[0]),
        .stored_second_lo (rdata_q[1][15:0]),
        .stored_err       (err_q[1:0]),
        .in_valid         (in_valid_i),
        .in_addr          (in_addr_i),
        .in_rdata         (in_rdata_i),
        .in_err           (in_err_i),
        .out_valid        (out_valid_o),
        .out_addr         (out_addr_o),
        .out_rdata        (out_rdata_o),
        .out_err          (out_err_o),
        .out_compressed   (out_is_compressed_o),
        .out_valid_stored (out_valid_stored_o)
    );

    // One slot of slack covers a request already issued to memory.
    assign in_ready_o = ~valid_q[DEPTH-2];

    assign deq     = out_valid_o & out_ready_i & ~clear_i;
    // An aligned compressed instruction leaves its upper half in the head word.
    assign pop     = deq & (out_addr_o[1] | ~out_is_compressed_o);
    assign pc_next = out_addr_o[PC_W-1:0] + (out_is_compressed_o ? PC_W'(2) : PC_W'(4));

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        placed  = 1'b0;
        if (clear_i) begin
            valid_d = '0;
        end else begin
            // Enqueue first so a word consumed on arrival is shifted straight out.
            if (in_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!valid_d[i] && !placed) begin
                        valid_d[i] = 1'b1;
                        addr_d[i]  = in_addr_i;
                        rdata_d[i] = in_rdata_i;
                        err_d[i]   = in_err_i;
                        placed     = 1'b1;
                    end
                end
            end
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    valid_d[i] = valid_d[i+1];
                    addr_d[i]  = addr_d[i+1];
                    rdata_d[i] = rdata_d[i+1];
                    err_d[i]   = err_d[i+1];
                end
                valid_d[DEPTH-1] = 1'b0;
                addr_d[DEPTH-1]  = '0;
                rdata_d[DEPTH-1] = '0;
                err_d[DEPTH-1]   = 1'b0;
            end
            if (deq) begin
                addr_d[0]             = out_addr_o;
                addr_d[0][PC_W-1:0]   = pc_next;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            // NOTE: the storage array is reset too, so stored addresses start at RESET_ADDR rather than X.
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= RESET_ADDR;
                rdata_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge state.
            valid_q <= valid_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ibex_cap_fetch_fifo.sv
// Directed bench for ibex_cap_fetch_fifo: expected instructions are queued when stimulus
// is driven and popped when the FIFO hands an instruction to the consumer.
module tb_ibex_cap_fetch_fifo;
    import ibex_cap_pkg::*;

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned ADDR_W = CAP_W;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_rdata;
    logic              in_err;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rdata;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic              out_is_compressed;
    logic              out_valid_stored;

    int checks = 0;
    int errors = 0;
    fifo_entry_t sb[$];

    ibex_cap_fetch_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .RESET_ADDR ('0)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .clear_i             (clear),
        .in_addr_i           (in_addr),
        .in_rdata_i          (in_rdata),
        .in_err_i            (in_err),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .out_rdata_o         (out_rdata),
        .out_addr_o          (out_addr),
        .out_err_o           (out_err),
        .out_is_compressed_o (out_is_compressed),
        .out_valid_stored_o  (out_valid_stored)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] pc(input logic [31:0] p);
        return ADDR_W'(p);
    endfunction

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic e);
        in_valid = v;
        in_addr  = a;
        in_rdata = d;
        in_err   = e;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic e);
        sb.push_back('{addr: a, rdata: d, err: e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Called at a sampling point where the consumer is ready and an instruction is due.
    task automatic expect_out(input string tag);
        fifo_entry_t exp;
        check({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end else begin
            exp = sb.pop_front();
            check({tag, "_addr"},  128'(out_addr),  128'(exp.addr));
            check({tag, "_rdata"}, 128'(out_rdata), 128'(exp.rdata));
            check({tag, "_err"},   128'(out_err),   128'(exp.err));
            check({tag, "_compressed"}, 128'(out_is_compressed),
                  128'(is_compressed(exp.rdata[1:0])));
        end
    endtask

    // Writing into a full FIFO is a protocol violation by the stimulus.
    always @(negedge clk) begin
        if (rst_n && !clear) begin
            assert (!(in_valid && dut.valid_q[DEPTH-1])) else begin
                errors++;
                $error("FAIL overflow: observed in_valid with full fifo expected no write");
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Reset state
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_valid_stored", 128'(out_valid_stored), 128'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();

        // Aligned stream, zero-latency pass-through
        out_ready = 1'b1;
        drive(1'b1, pc(32'h100), 32'h0000_0013, 1'b0);
        push_exp(pc(32'h100), 32'h0000_0013, 1'b0);
        sample();
        expect_out("aligned0");
        tick();
        drive(1'b1, pc(32'h104), 32'h0000_0093, 1'b0);
        push_exp(pc(32'h104), 32'h0000_0093, 1'b0);
        sample();
        expect_out("aligned1");
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        check("aligned_drained_valid", 128'(out_valid), 128'(1'b0));
        check("aligned_drained_stored", 128'(out_valid_stored), 128'(1'b0));
        tick();

        // Two compressed instructions in one word: one pop, after the second
        drive(1'b1, pc(32'h200), 32'h4505_4501, 1'b0);
        push_exp(pc(32'h200), 32'h4505_4501, 1'b0);
        sample();
        expect_out("cpair0");
        tick();
        drive(1'b0, '0, '0, 1'b0);
        push_exp(pc(32'h202), 32'h0000_4505, 1'b0);
        sample();
        check("cpair_kept_stored", 128'(out_valid_stored), 128'(1'b1));
        expect_out("cpair1");
        tick();
        sample();
        check("cpair_popped_stored", 128'(out_valid_stored), 128'(1'b0));
        tick();

        // Uncompressed instruction straddling two words
        drive(1'b1, pc(32'h302), 32'h0513_ABCD, 1'b0);
        sample();
        check("straddle_wait0_valid", 128'(out_valid), 128'(1'b0));
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        check("straddle_wait1_valid", 128'(out_valid), 128'(1'b0));
        check("straddle_wait1_stored", 128'(out_valid_stored), 128'(1'b0));
        tick();
        drive(1'b1, pc(32'h304), 32'h1234_0000, 1'b0);
        push_exp(pc(32'h302), 32'h0000_0513, 1'b0);
        sample();
        expect_out("straddle");
        tick();
        drive(1'b0, '0, '0, 1'b0);
        push_exp(pc(32'h306), 32'h0000_1234, 1'b0);
        sample();
        expect_out("after_straddle");
        tick();
        sample();
        check("straddle_drained_stored", 128'(out_valid_stored), 128'(1'b0));
        tick();

        // Metadata preserved across a PC wrap
        out_ready = 1'b0;
        drive(1'b1, {61'h1ABC, 32'hFFFF_FFFC}, 32'h0000_0013, 1'b0);
        sample();
        check("wrap_head_addr", 128'(out_addr), 128'({61'h1ABC, 32'hFFFF_FFFC}));
        tick();
        drive(1'b1, {61'h1ABC, 32'h0000_0000}, 32'h0000_0093, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        push_exp({61'h1ABC, 32'hFFFF_FFFC}, 32'h0000_0013, 1'b0);
        sample();
        expect_out("wrap0");
        tick();
        push_exp({61'h1ABC, 32'h0000_0000}, 32'h0000_0093, 1'b0);
        sample();
        expect_out("wrap1");
        tick();

        // Straddling instruction whose second word carries a bus error
        out_ready = 1'b0;
        drive(1'b1, pc(32'h602), 32'h0513_ABCD, 1'b0);
        tick();
        drive(1'b1, pc(32'h604), 32'h0000_0000, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        push_exp(pc(32'h602), 32'h0000_0513, 1'b1);
        sample();
        expect_out("err_second");
        tick();
        push_exp(pc(32'h606), 32'h0000_0000, 1'b1);
        sample();
        expect_out("err_tail");
        tick();

        // Fill with consumer stalled, error at the head, then clear with a colliding write
        out_ready = 1'b0;
        drive(1'b1, pc(32'h400), 32'h0000_0013, 1'b1);
        sample();
        check("fill0_in_ready", 128'(in_ready), 128'(1'b1));
        check("fill0_out_err", 128'(out_err), 128'(1'b1));
        tick();
        drive(1'b1, pc(32'h404), 32'h0000_0093, 1'b0);
        sample();
        check("fill1_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        drive(1'b1, pc(32'h408), 32'h0000_0113, 1'b0);
        sample();
        check("fill2_in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        check("full_in_ready", 128'(in_ready), 128'(1'b0));
        check("full_stored", 128'(out_valid_stored), 128'(1'b1));
        check("full_head_err", 128'(out_err), 128'(1'b1));
        check("full_head_addr", 128'(out_addr), 128'(pc(32'h400)));
        tick();
        clear = 1'b1;
        drive(1'b1, pc(32'h500), 32'h0000_0013, 1'b0);
        tick();
        clear = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        sample();
        check("clear_stored", 128'(out_valid_stored), 128'(1'b0));
        check("clear_out_valid", 128'(out_valid), 128'(1'b0));
        check("clear_in_ready", 128'(in_ready), 128'(1'b1));
        tick();

        // Asynchronous reset in the middle of a cycle
        drive(1'b1, pc(32'h700), 32'h0000_0013, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        sample();
        check("prereset_stored", 128'(out_valid_stored), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_stored", 128'(out_valid_stored), 128'(1'b0));
        check("async_reset_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        rst_n = 1'b1;
        sample();
        check("postreset_stored", 128'(out_valid_stored), 128'(1'b0));

        check("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
